add_define: RTL and testbench

ADD_DEFINE -- requirements
Module: add_define

---
 rtl/add_define.sv | 81 ++++++++
 tb/tb_add_define.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/add_define.sv
// add_define: single-stage registered adder that adds a compile-time constant
// to each accepted operand. Ready/valid handshake on both sides; the result
// register supports full throughput (one result per cycle) and holds its
// contents while the consumer stalls.
module add_define #(
  parameter int          WIDTH     = 16,
  parameter int unsigned INCREMENT = 2,
  parameter int          SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] b,
  output logic             ovf
);

  // Increment zero-extended to WIDTH+1 bits so the carry lands in the top bit.
  localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INCREMENT);
  localparam logic [WIDTH:0]   INC_EXT = {1'b0, INC_W};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   sum;
  logic             accept;

  // The slot is free when empty or when its current result retires this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Unsigned addition one bit wider than the operand; bit WIDTH is the carry.
  assign sum = {1'b0, a} + INC_EXT;

  // Next-state for the result register: load on accept, clear valid on retire,
  // otherwise hold (covers the stall case).
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    out_valid_d = out_valid_q;
    b_d         = b_q;
    ovf_d       = ovf_q;
    if (accept) begin
      out_valid_d = 1'b1;
      ovf_d       = sum[WIDTH];
      if ((SATURATE != 0) && sum[WIDTH]) begin
        b_d = ALL_ONES;
      end else begin
        b_d = sum[WIDTH-1:0];
      end
    end else if (out_ready) begin
      // Result retired with nothing new behind it; data is kept, only valid drops.
      out_valid_d = 1'b0;
    end
  end

  // Result register; reset discards any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: reset is asynchronous, so it also wins over an accept on the same edge.
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      b_q         <= '0;
      ovf_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      out_valid_q <= out_valid_d;
      b_q         <= b_d;
      ovf_q       <= ovf_d;
    end
  end

  // Outputs come straight from flops: no combinational path from a to b.
  assign out_valid = out_valid_q;
  assign b         = b_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_define.sv
// tb_add_define: directed self-checking bench for add_define. Three instances
// share one stimulus stream: wrap-around (INCREMENT=2), saturating
// (INCREMENT=2) and pass-through (INCREMENT=0).
module tb_add_define;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] a;

  logic         in_ready_w, out_valid_w, ovf_w;
  logic [W-1:0] b_w;
  logic         in_ready_s, out_valid_s, ovf_s;
  logic [W-1:0] b_s;
  logic         in_ready_z, out_valid_z, ovf_z;
  logic [W-1:0] b_z;

  int n_checks = 0;
  int n_fails  = 0;

  add_define #(.WIDTH(W), .INCREMENT(2), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .out_valid(out_valid_w), .out_ready(out_ready), .b(b_w), .ovf(ovf_w)
  );

  add_define #(.WIDTH(W), .INCREMENT(2), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .out_valid(out_valid_s), .out_ready(out_ready), .b(b_s), .ovf(ovf_s)
  );

  add_define #(.WIDTH(W), .INCREMENT(0), .SATURATE(0)) u_zero (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z),
    .a(a), .out_valid(out_valid_z), .out_ready(out_ready), .b(b_z), .ovf(ovf_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] av, input logic r);
    in_valid  = v;
    a         = av;
    out_ready = r;
    #1;
  endtask

  // Watchdog so the run always ends on its own.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 16'd50, 1'b0);
    #1;
    check("rst_out_valid", out_valid_w, 1'b0);
    check("rst_b",         b_w,         16'h0);
    check("rst_ovf",       ovf_w,       1'b0);
    check("rst_in_ready",  in_ready_w,  1'b1);
    cycle();
    check("rst_no_accept", out_valid_w, 1'b0);
    check("rst_no_accept_b", b_w, 16'h0);

    // Release reset away from any clock edge.
    drive(1'b0, 16'd0, 1'b0);
    rst_n = 1'b1;
    cycle();

    // a=14 -> b=16, ovf=0, one cycle latency.
    drive(1'b1, 16'd14, 1'b1);
    check("idle_in_ready", in_ready_w, 1'b1);
    check("pre_valid", out_valid_w, 1'b0);
    cycle();
    check("a14_valid", out_valid_w, 1'b1);
    check("a14_b",     b_w,         16'd16);
    check("a14_b_plus1", b_w + 16'd1, 16'd17);
    check("a14_ovf",   ovf_w,       1'b0);
    check("a14_sat_b", b_s,         16'd16);
    check("a14_zero_b", b_z,        16'd14);

    // Retire without new input: valid drops, data held.
    drive(1'b0, 16'd999, 1'b1);
    cycle();
    check("retire_valid", out_valid_w, 1'b0);
    check("retire_b",     b_w,         16'd16);

    // Wrap vs saturate on overflow, then largest non-overflowing operand.
    drive(1'b1, 16'hFFFF, 1'b1);
    cycle();
    check("ffff_wrap_b",   b_w,   16'h0001);
    check("ffff_wrap_ovf", ovf_w, 1'b1);
    check("ffff_sat_b",    b_s,   16'hFFFF);
    check("ffff_sat_ovf",  ovf_s, 1'b1);
    check("ffff_zero_b",   b_z,   16'hFFFF);
    check("ffff_zero_ovf", ovf_z, 1'b0);
    drive(1'b1, 16'hFFFD, 1'b1);
    cycle();
    check("fffd_wrap_b",   b_w,   16'hFFFF);
    check("fffd_wrap_ovf", ovf_w, 1'b0);
    check("fffd_sat_b",    b_s,   16'hFFFF);
    check("fffd_sat_ovf",  ovf_s, 1'b0);

    drive(1'b1, 16'hFFFE, 1'b1);
    cycle();
    check("fffe_sat_b",    b_s,   16'hFFFF);
    check("fffe_sat_ovf",  ovf_s, 1'b1);
    check("fffe_wrap_b",   b_w,   16'h0000);
    check("fffe_wrap_ovf", ovf_w, 1'b1);
    drive(1'b1, 16'h1000, 1'b1);
    cycle();
    check("1000_sat_b",    b_s,   16'h1002);
    check("1000_sat_ovf",  ovf_s, 1'b0);
    check("1000_valid",    out_valid_s, 1'b1);

    drive(1'b0, 16'd0, 1'b1);
    cycle();
    check("drain_valid", out_valid_w, 1'b0);

    // Stall: accept 5, then hold out_ready=0 for three cycles while offering 100.
    drive(1'b1, 16'd5, 1'b1);
    cycle();
    check("a5_b", b_w, 16'd7);
    drive(1'b1, 16'd100, 1'b0);
    check("stall_in_ready", in_ready_w, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_b",        b_w,         16'd7);
      check("stall_valid",    out_valid_w, 1'b1);
      check("stall_in_ready", in_ready_w,  1'b0);
    end
    drive(1'b1, 16'd100, 1'b1);
    check("unstall_in_ready", in_ready_w, 1'b1);
    cycle();
    check("a100_b",     b_w,         16'd102);
    check("a100_valid", out_valid_w, 1'b1);

    drive(1'b0, 16'd0, 1'b1);
    cycle();
    check("drain2_valid", out_valid_w, 1'b0);

    // Empty slot accepts even with out_ready=0.
    drive(1'b1, 16'd20, 1'b0);
    check("empty_in_ready", in_ready_w, 1'b1);
    cycle();
    check("a20_b",     b_w,         16'd22);
    check("a20_valid", out_valid_w, 1'b1);
    drive(1'b0, 16'd0, 1'b1);
    cycle();
    check("drain3_valid", out_valid_w, 1'b0);

    // Back-to-back throughput.
    drive(1'b1, 16'd1, 1'b1);
    cycle();
    check("b2b_1_b", b_w, 16'd3);
    check("b2b_1_v", out_valid_w, 1'b1);
    drive(1'b1, 16'd2, 1'b1);
    cycle();
    check("b2b_2_b", b_w, 16'd4);
    check("b2b_2_v", out_valid_w, 1'b1);
    drive(1'b1, 16'd3, 1'b1);
    cycle();
    check("b2b_3_b", b_w, 16'd5);
    check("b2b_3_v", out_valid_w, 1'b1);

    // Mid-cycle reset with a pending result of 16.
    drive(1'b1, 16'd14, 1'b1);
    cycle();
    check("prerst_b", b_w, 16'd16);
    drive(1'b0, 16'd0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid_w, 1'b0);
    check("async_rst_b",     b_w,         16'h0);
    check("async_rst_ovf",   ovf_w,       1'b0);
    check("async_rst_sat_b", b_s,         16'h0);
    check("async_rst_ready", in_ready_w,  1'b1);
    #1;
    rst_n = 1'b1;
    cycle();
    check("postrst_idle", out_valid_w, 1'b0);
    drive(1'b1, 16'd14, 1'b1);
    cycle();
    check("postrst_valid", out_valid_w, 1'b1);
    check("postrst_b",     b_w,         16'd16);
    check("postrst_ovf",   ovf_w,       1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
